// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC, fetches from instruction memory and hands words to decode.
// Optional fetch-ack watchdog is compiled in when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        br_req,
    input  logic [15:0] br_imm16,
    input  logic        jmp_req,
    input  logic [25:0] jmp_imm26,
    input  logic [31:0] redir_pc,
    output logic [31:0] pc,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, OUT, HALTED} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_imem_req, w_imem_req_nxt;
    logic [31:0] r_imem_addr, w_imem_addr_nxt;
    logic        r_inst_valid, w_inst_valid_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    logic        w_redir;
    logic [31:0] w_target;
    logic        w_start_ok;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;
    assign w_start_ok  = start && !r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    // Watchdog limit only matters when the watchdog is built in.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_start_ok  = start;
    assign timeout_err = 1'b0;
`endif

    // Jump beats branch when both arrive together; redirects only matter while fetching.
    assign w_target = jmp_req ? {redir_pc[31:28], jmp_imm26, 2'b00}
                              : redir_pc + 32'd1 + {{16{br_imm16[15]}}, br_imm16};
    assign w_redir  = (br_req || jmp_req) && (r_state == REQ || r_state == OUT);

    always_comb begin
        // NOTE: every next value defaults to its current register, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_kill_nxt      = r_kill;
        w_imem_addr_nxt = r_imem_addr;
        w_inst_nxt      = r_inst;
        w_inst_pc_nxt   = r_inst_pc;
`ifdef FETCH_TIMEOUT_EN
        w_tcnt_nxt        = r_tcnt;
        w_timeout_err_nxt = r_timeout_err;
`endif
        case (r_state)
            IDLE, HALTED: begin
                if (w_start_ok) begin
                    w_state_nxt     = REQ;
                    w_imem_addr_nxt = r_pc;
`ifdef FETCH_TIMEOUT_EN
                    w_tcnt_nxt = '0;
`endif
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (w_redir || r_kill) begin
                        // Response belongs to a squashed path: drop it and refetch at the new pc.
                        w_pc_nxt        = w_redir ? w_target : r_pc;
                        w_imem_addr_nxt = w_redir ? w_target : r_pc;
                        w_kill_nxt      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        w_tcnt_nxt = '0;
`endif
                    end else begin
                        w_inst_nxt    = imem_data;
                        w_inst_pc_nxt = r_imem_addr;
                        w_pc_nxt      = r_pc + 32'd1;
                        w_state_nxt   = OUT;
                    end
                end else begin
                    if (w_redir) begin
                        w_pc_nxt   = w_target;
                        w_kill_nxt = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_timeout_err_nxt = 1'b1;
                        w_kill_nxt        = 1'b0;
                        w_state_nxt       = HALTED;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
`endif
                end
            end
            OUT: begin
                if (w_redir) begin
                    w_pc_nxt        = w_target;
                    w_imem_addr_nxt = w_target;
                    w_state_nxt     = REQ;
`ifdef FETCH_TIMEOUT_EN
                    w_tcnt_nxt = '0;
`endif
                end else if (inst_ready) begin
                    if (halt) begin
                        w_state_nxt = HALTED;
                    end else begin
                        w_state_nxt     = REQ;
                        w_imem_addr_nxt = r_pc;
`ifdef FETCH_TIMEOUT_EN
                        w_tcnt_nxt = '0;
`endif
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_imem_req_nxt   = (w_state_nxt == REQ);
        w_inst_valid_nxt = (w_state_nxt == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values computed above.
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_imem_req   <= w_imem_req_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
`ifdef FETCH_TIMEOUT_EN
            r_tcnt        <= w_tcnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc         = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory responder, expected-instruction scoreboard, directed scenarios.
// Watchdog scenario is built only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        br_req, jmp_req;
    logic [15:0] br_imm16;
    logic [25:0] jmp_imm26;
    logic [31:0] redir_pc, pc;
    logic        timeout_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    bit   mem_en    = 1'b1;

    fetch_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .br_req     (br_req),
        .br_imm16   (br_imm16),
        .jmp_req    (jmp_req),
        .jmp_imm26  (jmp_imm26),
        .redir_pc   (redir_pc),
        .pc         (pc),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    // Called at a negedge after the scenario has set its inputs: drives the memory, scores
    // any handshake that the coming posedge will complete, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (imem_req && mem_en) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(imem_addr);
                wait_cnt  = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ack  = 1'b0;
            imem_data = 32'hDEAD_BEEF;
            wait_cnt  = 0;
        end
        if (inst_valid && inst_ready && !br_req && !jmp_req) begin
            check("inst_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst, e.data);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_data = '0;
        inst_ready = 1'b0; br_req = 1'b0; br_imm16 = '0; jmp_req = 1'b0; jmp_imm26 = '0; redir_pc = '0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Redirects are ignored while idle.
        br_req = 1'b1; redir_pc = 32'h40; br_imm16 = 16'h0003; tick(); br_req = 1'b0;
        check("idle_pc", pc, 0);
        check("idle_req", imem_req, 0);

        // Sequential fetch, zero-wait memory, downstream always ready.
        start = 1'b1; inst_ready = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq_req%0d", i), imem_req, 1);
            check($sformatf("seq_addr%0d", i), imem_addr, i);
            expect_inst(i);
            tick();
            check($sformatf("seq_valid%0d", i), inst_valid, 1);
            check($sformatf("seq_ipc%0d", i), inst_pc, i);
            tick();
        end

        // Branch while holding an instruction in OUT, even with ready high.
        inst_ready = 1'b0; tick();
        check("br_out_valid", inst_valid, 1);
        check("br_out_ipc", inst_pc, 4);
        br_req = 1'b1; redir_pc = 32'd10; br_imm16 = 16'hFFFC; inst_ready = 1'b1; tick(); br_req = 1'b0;
        check("br_drop_valid", inst_valid, 0);
        check("br_pc", pc, 7);
        check("br_req", imem_req, 1);
        check("br_addr", imem_addr, 7);
        expect_inst(7); tick(); tick();

        // Jump and branch together: jump wins.
        inst_ready = 1'b0; tick();
        jmp_req = 1'b1; br_req = 1'b1; redir_pc = 32'hA000_0000; jmp_imm26 = 26'h1; br_imm16 = 16'h0005;
        tick(); jmp_req = 1'b0; br_req = 1'b0;
        check("jb_addr", imem_addr, 32'hA000_0004);
        check("jb_valid", inst_valid, 0);
        expect_inst(32'hA000_0004); inst_ready = 1'b1; tick(); tick();

        // Branch in REQ with a slow ack, then a second redirect while the killed fetch is outstanding.
        ack_delay = 3;
        br_req = 1'b1; redir_pc = 32'h100; br_imm16 = 16'h0010; tick(); br_req = 1'b0;
        check("kill_pc", pc, 32'h111);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("kill_req%0d", k), imem_req, 1);
            check($sformatf("kill_addr%0d", k), imem_addr, 32'hA000_0005);
            check($sformatf("kill_valid%0d", k), inst_valid, 0);
            if (k == 0) begin
                jmp_req = 1'b1; redir_pc = 32'h2000_0000; jmp_imm26 = 26'h10;
            end
            tick();
            jmp_req = 1'b0;
        end
        check("kill_last_pc", pc, 32'h2000_0040);
        check("kill_refetch", imem_addr, 32'h2000_0040);
        check("kill_no_valid", inst_valid, 0);
        ack_delay = 0;
        expect_inst(32'h2000_0040); tick(); tick();

        // Redirect in the same cycle as the ack discards the response.
        br_req = 1'b1; redir_pc = 32'h0; br_imm16 = 16'h0004; tick(); br_req = 1'b0;
        check("ackredir_valid", inst_valid, 0);
        check("ackredir_addr", imem_addr, 5);

        // Halt at acceptance of pc=5, redirect ignored while halted, then resume at 6.
        expect_inst(5); halt = 1'b1; tick();
        check("halt_ipc", inst_pc, 5);
        tick(); halt = 1'b0;
        check("halt_req", imem_req, 0);
        check("halt_valid", inst_valid, 0);
        check("halt_pc", pc, 6);
        br_req = 1'b1; redir_pc = 32'h300; br_imm16 = 16'h0001; tick(); br_req = 1'b0;
        check("halt_redir_pc", pc, 6);
        check("halt_redir_req", imem_req, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("resume_req", imem_req, 1);
        check("resume_addr", imem_addr, 6);
        expect_inst(6); tick(); tick();

        // Asynchronous reset drops an outstanding request immediately.
        ack_delay = 100; tick();
        check("mid_req", imem_req, 1);
        check("mid_addr", imem_addr, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_pc", pc, 0);
        check("arst_valid", inst_valid, 0);
        @(negedge clk); rst = 1'b0; ack_delay = 0;
        tick();
        check("arst_idle_req", imem_req, 0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n_req;
            mem_en = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            n_req = 0;
            for (int c = 0; c < 40 && imem_req; c++) begin
                n_req++;
                tick();
            end
            check("to_req_cycles", n_req, 16);
            check("to_err", timeout_err, 1);
            check("to_req_drop", imem_req, 0);
            start = 1'b1; tick(); start = 1'b0;
            check("to_start_ignored", imem_req, 0);
            tick();
            check("to_still_halted", imem_req, 0);
            #2 rst = 1'b1;
            #1 check("to_rst_clear", timeout_err, 0);
            @(negedge clk); rst = 1'b0; mem_en = 1'b1;
        end
`endif

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
